ysyx_220053_alu_dispatch: RTL and testbench
===========================================

// Module: ysyx_220053_alu_dispatch
// PURPOSE
//  Decodes RV64I integer-ALU instructions (OP, OP-IMM, OP-32, OP-IMM-32, LUI, AUIPC) into
//  the 5-bit ALUOp and the A/B operands, and drives them into the EX-stage ALU.
//  Sits between the ID stage (register-file read) and the ALU.
//  Holds decoded ops in a 2-entry skid buffer with valid/ready on both sides.
//  in_ready is registered, so backpressure from EX never forms a combinational path to ID.
// PARAMETERS
//  XLEN   64  operand and PC width; only 64 is supported
// PORTS
//  clk          in   1     clock, single domain
//  rst_n        in   1     asynchronous active-low reset
//  in_valid     in   1     ID presents an instruction
//  in_ready     out  1     registered; 1 = a buffer slot is free
//  in_inst      in   32    raw instruction
//  in_pc        in   64    PC of in_inst
//  in_rs1       in   64    rs1 register-file read data
//  in_rs2       in   64    rs2 register-file read data
//  flush        in   1     kill all buffered ops (branch redirect)
//  out_valid    out  1     decoded op available to EX
//  out_ready    in   1     EX consumes the op this cycle
//  out_aluop    out  5     ALUOp to ALU
//  out_inputa   out  64    ALU operand A
//  out_inputb   out  64    ALU operand B
//  out_rd       out  5     destination register
//  out_wen      out  1     write-back enable; 0 if rd==0 or illegal
//  out_illegal  out  1     instruction is not a legal ALU instruction
// BEHAVIOUR
//  ALUOp codes:
//   ADD=00000, ADDW=10000, SLL=00001, SLLW=10001, SLT=00010, SLTU=00011
//   XOR=00100, SRL=00101, SRLW=10101, OR=00110, AND=00111
//   SUB=01000, SUBW=11000, SRA=01101, SRAW=11101, PASSB=01111
//  Operand mapping:
//   - inputa = in_rs1, except AUIPC: inputa = in_pc.
//   - inputb = in_rs2 for R-type; sign-extended I-imm for I-type.
//   - LUI/AUIPC: inputb = sign-extended {imm[31:12], 12'b0}.
//   - LUI uses PASSB; AUIPC uses ADD.
//  Shift immediates:
//   - 64-bit forms: shamt = inst[25:20]; funct7[6:1] must be 000000, or 010000 for SRAI.
//   - W forms: inst[25] must be 0.
//  Illegal:
//   - Any other opcode, or an undefined funct3/funct7 combination.
//   - Outputs aluop=00000, wen=0, illegal=1. The op is still passed downstream in order.
//  Buffer:
//   - Two slots: MAIN, which drives the out_* ports, and SKID.
//   - Decode happens before the slots, so latency is 1 cycle from acceptance to out_valid.
//   - States: EMPTY (0 entries), ONE (MAIN valid), TWO (MAIN and SKID valid).
//   - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
//   - EMPTY: accept -> ONE.
//   - ONE: accept & !pop -> TWO; pop & !accept -> EMPTY; accept & pop -> ONE (MAIN reloads).
//   - TWO: pop -> ONE (SKID moves to MAIN). in_ready=0, so no accept is possible.
//   - in_ready next value = (next state != TWO).
//   - out_valid = (state != EMPTY).
//   - out_* stay stable while out_valid & !out_ready.
//   - Strict FIFO order.
//  Flush:
//   - Next state EMPTY; out_valid=0 next cycle.
//   - An in_valid in the same cycle is dropped, even if in_ready=1.
//   - A pop in the same cycle still completes; EX sees it and must discard it itself.
//   - Flush has priority over every transition.
//  Reset (async, any time):
//   - State EMPTY; out_valid=0, in_ready=1.
//   - All out_* data = 0, out_wen=0, out_illegal=0.
//   - Reset mid-transfer drops buffered ops.
// STRUCTURE
//  Package ysyx_220053_alu_pkg:
//   - ALUOp localparams; opcode constants OP/OP_IMM/OP_32/OP_IMM_32/LUI/AUIPC.
//   - Buffer state enum; decoded-op struct {aluop, a, b, rd, wen, illegal}.
//  Sub-module ysyx_220053_alu_opdec:
//   - Pure combinational: inst, pc, rs1, rs2 -> decoded-op struct.
//   - Top level holds the skid FSM and the two slot registers.
// TESTING
//  - addi x5,x1,-1, rs1=5, out_ready=1 -> next cycle aluop=00000, a=5,
//    b=FFFF_FFFF_FFFF_FFFF, rd=5, wen=1.
//  - sraiw x3,x4,31 -> aluop=11101, b=0x1F.
//    Same with inst[25]=1 -> illegal=1, wen=0, aluop=00000.
//  - lui x7,0x80000 -> aluop=01111, b=FFFF_FFFF_8000_0000.
//    auipc at pc=0x8000_0000, imm=1 -> aluop=00000, a=0x8000_0000, b=0x1000.
//  - out_ready=0, three back-to-back ops -> two accepted, in_ready=0 from the following cycle.
//    Then release -> ops emerge in order on consecutive cycles.
//  - TWO state + flush, with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//    and the flush-cycle op is never output.
//  - rst_n low mid-stream for 1 cycle -> out_valid=0, in_ready=1, out_* = 0 immediately.
//  - add x0,x1,x2 -> wen=0, illegal=0.

Source files
------------

// File: rtl/ysyx_220053_alu_pkg.sv
// Shared definitions for the RV64I integer-ALU dispatch slice.
// Contents:
//   DATA_W           operand / PC width (64)
//   ALU_*            5-bit ALUOp encodings understood by the EX-stage ALU
//   OP .. AUIPC      major opcodes handled by the decoder
//   buf_state_e      occupancy of the two-slot output buffer
//   alu_op_t         one decoded op {aluop, a, b, rd, wen, illegal}
//   sext12()         sign-extend a 12-bit immediate to DATA_W
package ysyx_220053_alu_pkg;

   localparam int unsigned DATA_W = 64;

   localparam logic [4:0] ALU_ADD   = 5'b00000;
   localparam logic [4:0] ALU_ADDW  = 5'b10000;
   localparam logic [4:0] ALU_SLL   = 5'b00001;
   localparam logic [4:0] ALU_SLLW  = 5'b10001;
   localparam logic [4:0] ALU_SLT   = 5'b00010;
   localparam logic [4:0] ALU_SLTU  = 5'b00011;
   localparam logic [4:0] ALU_XOR   = 5'b00100;
   localparam logic [4:0] ALU_SRL   = 5'b00101;
   localparam logic [4:0] ALU_SRLW  = 5'b10101;
   localparam logic [4:0] ALU_OR    = 5'b00110;
   localparam logic [4:0] ALU_AND   = 5'b00111;
   localparam logic [4:0] ALU_SUB   = 5'b01000;
   localparam logic [4:0] ALU_SUBW  = 5'b11000;
   localparam logic [4:0] ALU_SRA   = 5'b01101;
   localparam logic [4:0] ALU_SRAW  = 5'b11101;
   localparam logic [4:0] ALU_PASSB = 5'b01111;

   localparam logic [6:0] OP        = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_32     = 7'b0111011;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] LUI       = 7'b0110111;
   localparam logic [6:0] AUIPC     = 7'b0010111;

   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_ONE,
      BUF_TWO
   } buf_state_e;

   typedef struct packed {
      logic [4:0]        aluop;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [4:0]        rd;
      logic              wen;
      logic              illegal;
   } alu_op_t;

   function automatic logic [DATA_W-1:0] sext12(input logic [11:0] imm);
      return {{(DATA_W-12){imm[11]}}, imm};
   endfunction

endpackage

// File: rtl/ysyx_220053_alu_opdec.sv
// Combinational decoder: raw RV64I ALU instruction plus its operands into an
// alu_op_t ready for the EX-stage ALU.
// Ports:
//   inst_i   32  raw instruction
//   pc_i     64  PC of inst_i (operand A for AUIPC)
//   rs1_i    64  rs1 read data
//   rs2_i    64  rs2 read data
//   op_o     --  decoded op; illegal encodings give aluop=ADD, a=b=0, wen=0, illegal=1
module ysyx_220053_alu_opdec
   import ysyx_220053_alu_pkg::*;
(
   input  logic [31:0]       inst_i,
   input  logic [DATA_W-1:0] pc_i,
   input  logic [DATA_W-1:0] rs1_i,
   input  logic [DATA_W-1:0] rs2_i,
   output alu_op_t           op_o
);

   logic [6:0]        opcode;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic [4:0]        rd;
   logic [DATA_W-1:0] imm_i;
   logic [DATA_W-1:0] imm_u;
   logic [DATA_W-1:0] shamt6;
   logic [DATA_W-1:0] shamt5;
   logic              unused_rs1_field;

   assign opcode = inst_i[6:0];
   assign rd     = inst_i[11:7];
   assign f3     = inst_i[14:12];
   assign f7     = inst_i[31:25];
   assign imm_i  = sext12(inst_i[31:20]);
   assign imm_u  = {{(DATA_W-32){inst_i[31]}}, inst_i[31:12], 12'h000};
   assign shamt6 = {{(DATA_W-6){1'b0}}, inst_i[25:20]};
   assign shamt5 = {{(DATA_W-5){1'b0}}, inst_i[24:20]};
   // Register indices are resolved upstream; only the data arrives here.
   assign unused_rs1_field = ^inst_i[19:15];

   logic              legal;
   logic [4:0]        aluop;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;

   always_comb begin
      legal = 1'b1;
      aluop = ALU_ADD;
      opa   = rs1_i;
      opb   = rs2_i;
      case (opcode)
         OP: begin
            // With funct7=0 the base ALUOp is simply {2'b00, funct3}.
            if (f7 == 7'b0000000) begin
               aluop = {2'b00, f3};
            end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
               aluop = ALU_SUB;
            end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
               aluop = ALU_SRA;
            end else begin
               legal = 1'b0;
            end
         end
         OP_IMM: begin
            opb = imm_i;
            case (f3)
               3'd1: begin
                  opb = shamt6;
                  if (inst_i[31:26] == 6'b000000) aluop = ALU_SLL;
                  else                            legal = 1'b0;
               end
               3'd5: begin
                  opb = shamt6;
                  if (inst_i[31:26] == 6'b000000)      aluop = ALU_SRL;
                  else if (inst_i[31:26] == 6'b010000) aluop = ALU_SRA;
                  else                                 legal = 1'b0;
               end
               default: aluop = {2'b00, f3};
            endcase
         end
         OP_32: begin
            if (f7 == 7'b0000000 && f3 == 3'd0)      aluop = ALU_ADDW;
            else if (f7 == 7'b0000000 && f3 == 3'd1) aluop = ALU_SLLW;
            else if (f7 == 7'b0000000 && f3 == 3'd5) aluop = ALU_SRLW;
            else if (f7 == 7'b0100000 && f3 == 3'd0) aluop = ALU_SUBW;
            else if (f7 == 7'b0100000 && f3 == 3'd5) aluop = ALU_SRAW;
            else                                     legal = 1'b0;
         end
         OP_IMM_32: begin
            opb = shamt5;
            // Full funct7 compare also enforces inst[25]=0 on the W shifts.
            if (f3 == 3'd0) begin
               aluop = ALU_ADDW;
               opb   = imm_i;
            end else if (f3 == 3'd1 && f7 == 7'b0000000) begin
               aluop = ALU_SLLW;
            end else if (f3 == 3'd5 && f7 == 7'b0000000) begin
               aluop = ALU_SRLW;
            end else if (f3 == 3'd5 && f7 == 7'b0100000) begin
               aluop = ALU_SRAW;
            end else begin
               legal = 1'b0;
            end
         end
         LUI: begin
            aluop = ALU_PASSB;
            opb   = imm_u;
         end
         AUIPC: begin
            aluop = ALU_ADD;
            opa   = pc_i;
            opb   = imm_u;
         end
         default: legal = 1'b0;
      endcase
   end

   // Illegal ops still travel downstream in order, with neutral operands.
   assign op_o.aluop   = legal ? aluop : ALU_ADD;
   assign op_o.a       = legal ? opa : '0;
   assign op_o.b       = legal ? opb : '0;
   assign op_o.rd      = rd;
   assign op_o.wen     = legal && (rd != 5'd0);
   assign op_o.illegal = ~legal;

endmodule

// File: rtl/ysyx_220053_alu_dispatch.sv
// ID->EX dispatch for RV64I integer-ALU ops: decodes, then holds ops in a
// two-slot (MAIN + SKID) buffer with valid/ready on both sides. in_ready is
// registered so EX backpressure never reaches ID combinationally.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           ID handshake (in_ready registered)
//   in_inst/in_pc/in_rs1/in_rs2 instruction, PC and register data
//   flush                       drop all buffered ops and the same-cycle input
//   out_valid/out_ready         EX handshake
//   out_aluop/out_inputa/out_inputb/out_rd/out_wen/out_illegal  decoded op (MAIN slot)
module ysyx_220053_alu_dispatch
   import ysyx_220053_alu_pkg::*;
#(
   parameter int unsigned XLEN = 64  // only 64 is supported
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_aluop,
   output logic [XLEN-1:0] out_inputa,
   output logic [XLEN-1:0] out_inputb,
   output logic [4:0]      out_rd,
   output logic            out_wen,
   output logic            out_illegal
);

   alu_op_t    dec;
   alu_op_t    main_q, main_d;
   alu_op_t    skid_q, skid_d;
   buf_state_e state_q, state_d;
   logic       in_ready_q;
   logic       accept;
   logic       pop;

   ysyx_220053_alu_opdec u_opdec (
      .inst_i (in_inst),
      .pc_i   (in_pc),
      .rs1_i  (in_rs1),
      .rs2_i  (in_rs2),
      .op_o   (dec)
   );

   // Flush swallows the same-cycle input, so it is masked out of accept here.
   assign accept = in_valid & in_ready_q & ~flush;
   assign pop    = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         BUF_EMPTY: begin
            if (accept) begin
               state_d = BUF_ONE;
               main_d  = dec;
            end
         end
         BUF_ONE: begin
            if (accept && pop) begin
               main_d = dec;
            end else if (accept) begin
               state_d = BUF_TWO;
               skid_d  = dec;
            end else if (pop) begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_TWO: begin
            if (pop) begin
               state_d = BUF_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
      if (flush) begin
         state_d = BUF_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BUF_EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != BUF_TWO);
         main_q     <= main_d;
         skid_q     <= skid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state_q != BUF_EMPTY);
   assign out_aluop   = main_q.aluop;
   assign out_inputa  = main_q.a;
   assign out_inputb  = main_q.b;
   assign out_rd      = main_q.rd;
   assign out_wen     = main_q.wen;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_ysyx_220053_alu_dispatch.sv
module tb_ysyx_220053_alu_dispatch;
   import ysyx_220053_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc;
   logic [63:0] in_rs1;
   logic [63:0] in_rs2;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_aluop;
   logic [63:0] out_inputa;
   logic [63:0] out_inputb;
   logic [4:0]  out_rd;
   logic        out_wen;
   logic        out_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   alu_op_t exp_cur;
   alu_op_t sb[$];

   localparam logic [63:0] R1 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] R2 = 64'hFEDC_BA98_7654_3210;

   ysyx_220053_alu_dispatch #(.XLEN(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_pc       (in_pc),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_aluop   (out_aluop),
      .out_inputa  (out_inputa),
      .out_inputb  (out_inputb),
      .out_rd      (out_rd),
      .out_wen     (out_wen),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   function automatic alu_op_t mk(input logic [4:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic [4:0] rd,
                                  input logic wen, input logic ill);
      alu_op_t r;
      r.aluop   = op;
      r.a       = a;
      r.b       = b;
      r.rd      = rd;
      r.wen     = wen;
      r.illegal = ill;
      return r;
   endfunction

   // Scoreboard: handshakes are sampled mid-cycle, before the edge that commits them.
   always @(negedge clk) begin : monitor
      alu_op_t got;
      alu_op_t e;
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            got.aluop   = out_aluop;
            got.a       = out_inputa;
            got.b       = out_inputb;
            got.rd      = out_rd;
            got.wen     = out_wen;
            got.illegal = out_illegal;
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output: actual aluop=%b a=%h b=%h rd=%0d, required no output",
                        got.aluop, got.a, got.b, got.rd);
            end else begin
               e = sb.pop_front();
               if (got !== e) begin
                  n_fail++;
                  $display("FAIL sb_output: actual aluop=%b a=%h b=%h rd=%0d wen=%b ill=%b, required aluop=%b a=%h b=%h rd=%0d wen=%b ill=%b",
                           got.aluop, got.a, got.b, got.rd, got.wen, got.illegal,
                           e.aluop, e.a, e.b, e.rd, e.wen, e.illegal);
               end
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back(exp_cur);
      end
   end

   task automatic drive(input logic [31:0] inst, input logic [63:0] pc,
                        input logic [63:0] rs1, input logic [63:0] rs2, input alu_op_t e);
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
      in_rs1   = rs1;
      in_rs2   = rs2;
      exp_cur  = e;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      in_inst   = '0;
      in_pc     = '0;
      in_rs1    = '0;
      in_rs2    = '0;
      exp_cur   = '0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: actual %b required 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: actual %b required 1", in_ready); end
      n_checks++; if (out_aluop !== 5'd0) begin n_fail++; $display("FAIL rst_aluop: actual %b required 0", out_aluop); end
      n_checks++; if (out_inputa !== 64'd0) begin n_fail++; $display("FAIL rst_inputa: actual %h required 0", out_inputa); end
      n_checks++; if (out_inputb !== 64'd0) begin n_fail++; $display("FAIL rst_inputb: actual %h required 0", out_inputb); end
      n_checks++; if (out_rd !== 5'd0) begin n_fail++; $display("FAIL rst_rd: actual %0d required 0", out_rd); end
      n_checks++; if (out_wen !== 1'b0) begin n_fail++; $display("FAIL rst_wen: actual %b required 0", out_wen); end
      n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal: actual %b required 0", out_illegal); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_decode;
      out_ready = 1'b1;
      // addi x5,x1,-1
      drive(32'hFFF08293, 64'h1000, 64'd5, R2, mk(5'b00000, 64'd5, '1, 5'd5, 1'b1, 1'b0));
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_out_valid: actual %b required 1", out_valid); end
      // sraiw x3,x4,31 and the same with inst[25]=1
      drive(32'h41F2519B, 64'h1000, R1, R2, mk(5'b11101, R1, 64'h1F, 5'd3, 1'b1, 1'b0));
      drive(32'h43F2519B, 64'h1000, R1, R2, mk(5'b00000, 64'd0, 64'd0, 5'd3, 1'b0, 1'b1));
      // lui x7,0x80000 / auipc x1,1
      drive(32'h800003B7, 64'h1000, R1, R2, mk(5'b01111, R1, 64'hFFFF_FFFF_8000_0000, 5'd7, 1'b1, 1'b0));
      drive(32'h00001097, 64'h8000_0000, R1, R2, mk(5'b00000, 64'h8000_0000, 64'h1000, 5'd1, 1'b1, 1'b0));
      // add x0,x1,x2 / sub x6,x1,x2
      drive(32'h00208033, 64'h1000, R1, R2, mk(5'b00000, R1, R2, 5'd0, 1'b0, 1'b0));
      drive(32'h40208333, 64'h1000, R1, R2, mk(5'b01000, R1, R2, 5'd6, 1'b1, 1'b0));
      // srai x9,x1,63 / slli x13,x1,32 (inst[25]=1 legal for 64-bit shifts)
      drive(32'h43F0D493, 64'h1000, R1, R2, mk(5'b01101, R1, 64'h3F, 5'd9, 1'b1, 1'b0));
      drive(32'h02009693, 64'h1000, R1, R2, mk(5'b00001, R1, 64'h20, 5'd13, 1'b1, 1'b0));
      // sllw x10,x1,x2 / sltiu x11,x1,5
      drive(32'h0020953B, 64'h1000, R1, R2, mk(5'b10001, R1, R2, 5'd10, 1'b1, 1'b0));
      drive(32'h0050B593, 64'h1000, R1, R2, mk(5'b00011, R1, 64'd5, 5'd11, 1'b1, 1'b0));
      // ecall (foreign opcode) / mul x12 (undefined funct7)
      drive(32'h00000073, 64'h1000, R1, R2, mk(5'b00000, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1));
      drive(32'h02208633, 64'h1000, R1, R2, mk(5'b00000, 64'd0, 64'd0, 5'd12, 1'b0, 1'b1));
      idle(3);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL decode_drain_valid: actual %b required 0", out_valid); end
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL decode_sb_drain: actual %0d pending required 0", sb.size()); end
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0;
      drive(32'hFFF08293, 64'h0, 64'd1, 64'd0, mk(5'b00000, 64'd1, '1, 5'd5, 1'b1, 1'b0));
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_one: actual %b required 1", in_ready); end
      drive(32'hFFF08293, 64'h0, 64'd2, 64'd0, mk(5'b00000, 64'd2, '1, 5'd5, 1'b1, 1'b0));
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_two: actual %b required 0", in_ready); end
      drive(32'hFFF08293, 64'h0, 64'd3, 64'd0, mk(5'b00000, 64'd3, '1, 5'd5, 1'b1, 1'b0));
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_hold: actual %b required 0", in_ready); end
      n_checks++; if (out_inputa !== 64'd1) begin n_fail++; $display("FAIL b2b_stable_a: actual %h required 1", out_inputa); end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_inputa !== 64'd2 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second: actual a=%h v=%b required a=2 v=1", out_inputa, out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_back: actual %b required 1", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: actual %b required 0", out_valid); end
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_sb_drain: actual %0d pending required 0", sb.size()); end
   endtask

   task automatic test_flush;
      out_ready = 1'b0;
      drive(32'hFFF08293, 64'h0, 64'h11, 64'd0, mk(5'b00000, 64'h11, '1, 5'd5, 1'b1, 1'b0));
      drive(32'hFFF08293, 64'h0, 64'h22, 64'd0, mk(5'b00000, 64'h22, '1, 5'd5, 1'b1, 1'b0));
      flush = 1'b1;
      drive(32'hFFF08293, 64'h0, 64'h33, 64'd0, mk(5'b00000, 64'h33, '1, 5'd5, 1'b1, 1'b0));
      flush = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_two_valid: actual %b required 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_two_ready: actual %b required 1", in_ready); end
      idle(2);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped_op: actual %b required 0", out_valid); end
      // Flush coinciding with a pop: the popped op is still delivered.
      drive(32'hFFF08293, 64'h0, 64'h44, 64'd0, mk(5'b00000, 64'h44, '1, 5'd5, 1'b1, 1'b0));
      out_ready = 1'b1;
      flush     = 1'b1;
      drive(32'hFFF08293, 64'h0, 64'h55, 64'd0, mk(5'b00000, 64'h55, '1, 5'd5, 1'b1, 1'b0));
      flush = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pop_valid: actual %b required 0", out_valid); end
      idle(2);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pop_idle: actual %b required 0", out_valid); end
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL flush_sb_drain: actual %0d pending required 0", sb.size()); end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      drive(32'h800003B7, 64'h0, R1, R2, mk(5'b01111, R1, 64'hFFFF_FFFF_8000_0000, 5'd7, 1'b1, 1'b0));
      drive(32'h40208333, 64'h0, R1, R2, mk(5'b01000, R1, R2, 5'd6, 1'b1, 1'b0));
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: actual %b required 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: actual %b required 1", in_ready); end
      n_checks++; if (out_aluop !== 5'd0) begin n_fail++; $display("FAIL mid_rst_aluop: actual %b required 0", out_aluop); end
      n_checks++; if (out_inputa !== 64'd0) begin n_fail++; $display("FAIL mid_rst_inputa: actual %h required 0", out_inputa); end
      n_checks++; if (out_inputb !== 64'd0) begin n_fail++; $display("FAIL mid_rst_inputb: actual %h required 0", out_inputb); end
      n_checks++; if (out_rd !== 5'd0 || out_wen !== 1'b0 || out_illegal !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_rd_wen_ill: actual rd=%0d wen=%b ill=%b required 0 0 0", out_rd, out_wen, out_illegal);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      drive(32'h00001097, 64'h8000_0000, R1, R2, mk(5'b00000, 64'h8000_0000, 64'h1000, 5'd1, 1'b1, 1'b0));
      idle(2);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_recover: actual %b required 0", out_valid); end
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL mid_rst_sb_drain: actual %0d pending required 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
